// File: rtl/ext_bus_pkg.sv
// ext_bus_pkg: shared types and constants for the external
// multiplexed address/data bus sequencer.
package ext_bus_pkg;

    localparam int WAIT_W = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_HOLD,
        S_TURN,
        S_STRB,
        S_END
    } state_e;

    typedef struct packed {
        logic        we;
        logic        gnt;
        logic [15:0] addr;
        logic [15:0] wdata;
    } xfer_t;

    localparam logic        LE_RST   = 1'b0;
    localparam logic        OE_N_RST = 1'b1;
    localparam logic        WE_N_RST = 1'b1;
    localparam logic        DIR_RST  = 1'b0;
    localparam logic [15:0] BUS_RST  = 16'h0000;

endpackage

// File: rtl/ext_bus_ctrl_rr_arb2.sv
// rr_arb2: two-request round-robin arbiter; the pointer holds the
// index of the last granted master and resets to 1.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    logic last_q;
    logic last_d;

    always_comb begin
        grant[0] = req[0] & (~req[1] | last_q);
        grant[1] = req[1] & (~req[0] | ~last_q);
        last_d   = last_q;
        if (advance && (|req)) begin
            last_d = grant[1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/ext_bus_ctrl.sv
// ext_bus_ctrl: arbitrates two masters onto the external muxed bus
// and sequences address latch, turnaround and OE/WE strobes.
module ext_bus_ctrl
    import ext_bus_pkg::*;
#(
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [15:0] m0_addr,
    input  logic [15:0] m0_wdata,
    output logic        m0_ack,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [15:0] m1_addr,
    input  logic [15:0] m1_wdata,
    output logic        m1_ack,
    output logic [15:0] rdata,
    output logic [15:0] bus_out,
    input  logic [15:0] bus_in,
    output logic        bus_dir,
    output logic        le,
    output logic        oe_n,
    output logic        we_n,
    output logic        busy
);

    localparam logic [WAIT_W-1:0] WS = WAIT_W'(WAIT_STATES);

    state_e            state_q, state_d;
    xfer_t             xfer_q, xfer_d;
    logic [WAIT_W-1:0] cnt_q, cnt_d;
    logic [15:0]       rdata_q, rdata_d;
    logic [15:0]       bus_out_q, bus_out_d;
    logic              le_q, le_d;
    logic              oe_n_q, oe_n_d;
    logic              we_n_q, we_n_d;
    logic              dir_q, dir_d;
    logic              ack0_q, ack0_d;
    logic              ack1_q, ack1_d;
    logic              busy_q, busy_d;
    logic [1:0]        grant;
    logic              advance;

    assign advance = (state_q == S_IDLE);

    rr_arb2 u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     ({m1_req, m0_req}),
        .advance (advance),
        .grant   (grant)
    );

    always_comb begin
        state_d = state_q;
        xfer_d  = xfer_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        unique case (state_q)
            S_IDLE: begin
                if (|grant) begin
                    state_d     = S_ADDR;
                    xfer_d.gnt  = grant[1];
                    xfer_d.we   = grant[1] ? m1_we : m0_we;
                    xfer_d.addr = grant[1] ? m1_addr : m0_addr;
                    xfer_d.wdata = grant[1] ? m1_wdata : m0_wdata;
                end
            end
            S_ADDR: state_d = S_HOLD;
            S_HOLD: begin
                state_d = xfer_q.we ? S_STRB : S_TURN;
                cnt_d   = WS;
            end
            S_TURN: state_d = S_STRB;
            S_STRB: begin
                if (cnt_q == '0) begin
                    state_d = S_END;
                    if (!xfer_q.we) begin
                        rdata_d = bus_in;
                    end
                end else begin
                    cnt_d = cnt_q - WAIT_W'(1);
                end
            end
            S_END:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Pins are decoded from the next state so every output is a flop.
    always_comb begin
        le_d      = 1'b0;
        oe_n_d    = 1'b1;
        we_n_d    = 1'b1;
        dir_d     = 1'b0;
        ack0_d    = 1'b0;
        ack1_d    = 1'b0;
        bus_out_d = bus_out_q;
        busy_d    = (state_d != S_IDLE);
        unique case (state_d)
            S_ADDR: begin
                le_d      = 1'b1;
                bus_out_d = xfer_d.addr;
            end
            S_HOLD: bus_out_d = xfer_d.addr;
            S_TURN: dir_d = 1'b1;
            S_STRB: begin
                if (xfer_d.we) begin
                    bus_out_d = xfer_d.wdata;
                    we_n_d    = 1'b0;
                end else begin
                    dir_d  = 1'b1;
                    oe_n_d = 1'b0;
                end
            end
            S_END: begin
                ack0_d = ~xfer_d.gnt;
                ack1_d = xfer_d.gnt;
                if (xfer_d.we) begin
                    bus_out_d = xfer_d.wdata;
                end else begin
                    dir_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            xfer_q    <= '0;
            cnt_q     <= '0;
            rdata_q   <= '0;
            bus_out_q <= BUS_RST;
            le_q      <= LE_RST;
            oe_n_q    <= OE_N_RST;
            we_n_q    <= WE_N_RST;
            dir_q     <= DIR_RST;
            ack0_q    <= 1'b0;
            ack1_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            xfer_q    <= xfer_d;
            cnt_q     <= cnt_d;
            rdata_q   <= rdata_d;
            bus_out_q <= bus_out_d;
            le_q      <= le_d;
            oe_n_q    <= oe_n_d;
            we_n_q    <= we_n_d;
            dir_q     <= dir_d;
            ack0_q    <= ack0_d;
            ack1_q    <= ack1_d;
            busy_q    <= busy_d;
        end
    end

    assign m0_ack  = ack0_q;
    assign m1_ack  = ack1_q;
    assign rdata   = rdata_q;
    assign bus_out = bus_out_q;
    assign bus_dir = dir_q;
    assign le      = le_q;
    assign oe_n    = oe_n_q;
    assign we_n    = we_n_q;
    assign busy    = busy_q;

endmodule

// File: doc/ext_bus_ctrl.md
# ext_bus_ctrl

Sequencer and two-master arbiter for the PDP-11 macro's external multiplexed 16-bit address/data bus. It shares the off-chip bus between the CPU (master 0) and a DMA/loader engine (master 1). It turns each granted word request into the pin-level cycle: address phase with a transparent-latch enable, bus turnaround, OE or WE strobe with programmable wait states, and strobe release. It sits between the CPU/DMA cores and the mprj_io pad mapping inside the PDP-11 wrapper.

## Interface
Parameters:
- WAIT_STATES, default 1: extra strobe cycles beyond the first, legal range 0..15.

Ports:
- clk  in  1  single clock for the whole block.
- rst_n  in  1  asynchronous, active-low reset.
- m0_req / m1_req  in  1  request level, held until the matching ack.
- m0_we / m1_we  in  1  1 means write, 0 means read. Valid while req is high.
- m0_addr / m1_addr  in  16  byte address. Bit 0 is driven onto the pins unchanged.
- m0_wdata / m1_wdata  in  16  write data.
- m0_ack / m1_ack  out  1  one-cycle completion pulse.
- rdata  out  16  read data, valid in the ack cycle, held until the next read completes.
- bus_out  out  16  pin data/address output.
- bus_in  in  16  pin input.
- bus_dir  out  1  1 means the external side drives the bus and the pins are inputs.
- le  out  1  address latch enable, transparent while high, captured on the falling edge.
- oe_n  out  1  active-low read strobe.
- we_n  out  1  active-low write strobe; the external side captures on its rising edge.
- busy  out  1  high in every state except IDLE.

## Operation
- States: IDLE, ADDR, HOLD, TURN, STRB, END.
- IDLE: arbitrate, then latch addr/we/wdata and the grant index into internal registers.
  - Nothing is sampled from the master again until ack.
- Arbitration is two-way round-robin. A last-grant pointer resets to 1, so m0 wins the first tie.
  - A sole requester always wins.
  - On a tie, the master not granted last wins.
- ADDR: le=1, bus_out=addr, bus_dir=0.
- HOLD: le=0 (the falling edge captures the address), bus_out=addr.
  - Read goes to TURN; write goes to STRB.
- TURN (read only): bus_dir=1, oe_n=1.
- STRB lasts 1+WAIT_STATES cycles, counted by a 4-bit down-counter.
  - Read: bus_dir=1, oe_n=0. bus_in is registered into rdata at the clock edge ending the last STRB cycle.
  - Write: bus_out=wdata, bus_dir=0, we_n=0.
- END: strobes deasserted and ack of the granted master = 1.
  - Write keeps bus_out=wdata and bus_dir=0, giving data hold past the rising edge of we_n.
  - Read keeps bus_dir=1.
- END always goes to IDLE. A master that keeps req high after its ack is issuing a new request, which IDLE samples.
- Only one ack is ever high in a cycle. le, oe_n=0 and we_n=0 are mutually exclusive.
- Reset, including mid-cycle: every output goes to its reset value immediately.
  - Reset values: le=0, oe_n=1, we_n=1, bus_dir=0, bus_out=0, acks=0, rdata=0, busy=0.
  - State goes to IDLE and the pointer to 1. The in-flight transfer is dropped and never acked.
- In IDLE, bus_out keeps the last driven value and bus_dir=0.

## Timing
- Cycle 0 is the IDLE cycle in which req is seen.
- Read: ADDR at cycle 1, HOLD 2, TURN 3, STRB 4..4+W, ack at cycle 5+W.
  - With W=1: ack at cycle 6, 7 cycles from request to next IDLE.
- Write: ADDR 1, HOLD 2, STRB 3..3+W, ack at cycle 4+W.
  - With W=1: ack at cycle 5.
- Back-to-back throughput is one transfer per (6+W) clocks for reads and (5+W) for writes.
- All outputs are registered; there are no combinational paths from inputs to pins.

## Structure
- Package ext_bus_pkg holds:
  - the state enum;
  - the WAIT_W=4 counter width;
  - localparam reset values for the pin outputs.
- Sub-module rr_arb2 is the two-request round-robin arbiter with pointer register. Interface: req[1:0] and advance in; grant[1:0] out.
- The pad mapping to mprj_io stays in the wrapper, not here.

## Test plan
- Single m0 read of 0x1000 with memory word 0xBEEF and W=1:
  - le high exactly in cycle 1, oe_n low in cycles 4-5, m0_ack at cycle 6 with rdata=0xBEEF;
  - external latch holds 0x1000 throughout.
- m1 write of 0x55AA to 0xFE00, W=0:
  - we_n low only in cycle 3, m1_ack at cycle 4;
  - the model sees 0x55AA at the rising edge of we_n;
  - bus_dir stays 0 throughout.
- m0 and m1 both request continuously, 4 transfers each:
  - grants alternate m0,m1,m0,m1 starting with m0;
  - no two acks coincide and no strobe overlap occurs.
- W=15 read: oe_n low for exactly 16 cycles, ack at cycle 20.
- rst_n asserted during STRB of a write:
  - we_n rises asynchronously, no ack is produced, all outputs reach reset values;
  - after release, a fresh m1 request completes normally.
- m0 holds req high with a changing address after ack:
  - the next IDLE starts a new transfer to the new address;
  - each transfer is acked exactly once.
